// File: rtl/quiesce_sequencer_if.sv
// Purpose : bundles the command, completion and per-slot quiesce request/response
//           signals of quiesce_sequencer.
// Ports   : master = sequencer side (drives cmd_ready, done_*, q_req_*);
//           slave  = environment side (drives cmd_*, q_resp_*).
interface quiesce_sequencer_if #(
  parameter int NUM_SLOTS = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [NUM_SLOTS-1:0] cmd_mask;
  logic                 done_valid;
  logic [NUM_SLOTS-1:0] done_quiesced;
  logic [NUM_SLOTS-1:0] done_timeout;
  logic [31:0]          done_cycles;
  logic [NUM_SLOTS-1:0] q_req_valid;
  logic                 q_req_is_request;
  logic [NUM_SLOTS-1:0] q_resp_valid;
  logic [NUM_SLOTS-1:0] q_resp_quiesced;

  modport master (
    input  cmd_valid, cmd_mask, q_resp_valid, q_resp_quiesced,
    output cmd_ready, done_valid, done_quiesced, done_timeout, done_cycles,
           q_req_valid, q_req_is_request
  );

  modport slave (
    output cmd_valid, cmd_mask, q_resp_valid, q_resp_quiesced,
    input  cmd_ready, done_valid, done_quiesced, done_timeout, done_cycles,
           q_req_valid, q_req_is_request
  );
endinterface

// File: rtl/quiesce_sequencer.sv
// Purpose : on a command, issues a quiesce request to every selected slot, then polls
//           each pending slot with status checks in sweeps separated by an idle gap,
//           until all slots report quiesced or the sweep limit is hit.
// Latency : zero-mask command completes the cycle after accept; otherwise
//           one cycle per issued slot plus check/gap time.
// Backpressure: cmd_ready only in IDLE; a check waits up to RESP_WAIT cycles.
// Ports   : clk, rst (sync, active-high); bus (quiesce_sequencer_if.master).
// Option  : define QUIESCE_SEQ_CYCLES_EN to build the command-duration counter
//           reported on done_cycles; otherwise done_cycles is tied to 0.
module quiesce_sequencer #(
  parameter int NUM_SLOTS  = 8,
  parameter int POLL_GAP   = 16,
  parameter int MAX_SWEEPS = 255,
  parameter int RESP_WAIT  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  quiesce_sequencer_if.master  bus
);

  localparam int IDX_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int SWP_W   = $clog2(MAX_SWEEPS + 1);
  localparam int CNT_MAX = (RESP_WAIT > POLL_GAP) ? RESP_WAIT : POLL_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, CHECK, GAP, DONE} state_t;

  // Returns {found, index} of the lowest set bit of mask at or above start.
  function automatic logic [IDX_W:0] lowest_from(input logic [NUM_SLOTS-1:0] mask,
                                                 input int start);
    logic [IDX_W:0] res;
    res = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (i >= start && mask[i]) res = {1'b1, IDX_W'(i)};
    end
    return res;
  endfunction

  state_t               r_state, w_state_nxt;
  logic [NUM_SLOTS-1:0] r_pending, w_pending_nxt;
  logic [NUM_SLOTS-1:0] r_quiesced, w_quiesced_nxt;
  logic [IDX_W-1:0]     r_slot, w_slot_nxt;
  logic [SWP_W-1:0]     r_sweep, w_sweep_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [NUM_SLOTS-1:0] r_done_q, r_done_t;

  logic                 w_accept;
  logic [IDX_W:0]       w_first_cmd, w_first_pend, w_next_pend;
  logic [NUM_SLOTS-1:0] w_slot_oh, w_clear_oh, w_pend_after;
  logic                 w_hit, w_clear, w_chk_end;
  logic [SWP_W-1:0]     w_sweep_inc;

  assign w_accept     = bus.cmd_valid && bus.cmd_ready;
  assign w_first_cmd  = lowest_from(bus.cmd_mask, 0);
  assign w_first_pend = lowest_from(r_pending, 0);
  assign w_next_pend  = lowest_from(r_pending, int'(r_slot) + 1);
  assign w_slot_oh    = {{(NUM_SLOTS-1){1'b0}}, 1'b1} << r_slot;

  // Only the slot currently being checked can end the check; other slots are ignored.
  assign w_hit        = bus.q_resp_valid[r_slot];
  assign w_clear      = w_hit && bus.q_resp_quiesced[r_slot];
  assign w_chk_end    = w_hit || (r_cnt == CNT_W'(RESP_WAIT - 1));
  assign w_clear_oh   = w_clear ? w_slot_oh : '0;
  assign w_pend_after = r_pending & ~w_clear_oh;
  assign w_sweep_inc  = r_sweep + SWP_W'(1);

  always_comb begin
    w_state_nxt    = r_state;
    w_pending_nxt  = r_pending;
    w_quiesced_nxt = r_quiesced;
    w_slot_nxt     = r_slot;
    w_sweep_nxt    = r_sweep;
    w_cnt_nxt      = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_pending_nxt  = bus.cmd_mask;
          w_quiesced_nxt = '0;
          w_sweep_nxt    = '0;
          w_cnt_nxt      = '0;
          w_slot_nxt     = w_first_cmd[IDX_W-1:0];
          w_state_nxt    = w_first_cmd[IDX_W] ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (w_next_pend[IDX_W]) begin
          w_slot_nxt = w_next_pend[IDX_W-1:0];
        end else begin
          w_slot_nxt  = w_first_pend[IDX_W-1:0];
          w_cnt_nxt   = '0;
          w_state_nxt = w_first_pend[IDX_W] ? CHECK : DONE;
        end
      end
      CHECK: begin
        if (!w_chk_end) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
          w_pending_nxt  = w_pend_after;
          w_quiesced_nxt = r_quiesced | w_clear_oh;
          w_cnt_nxt      = '0;
          if (w_next_pend[IDX_W]) begin
            w_slot_nxt = w_next_pend[IDX_W-1:0];
          end else if (w_pend_after == '0) begin
            w_state_nxt = DONE;
          end else begin
            // End of an unsuccessful sweep: count it, then give up or wait a gap.
            w_sweep_nxt = w_sweep_inc;
            w_state_nxt = (w_sweep_inc == SWP_W'(MAX_SWEEPS)) ? DONE : GAP;
          end
        end
      end
      GAP: begin
        if (r_cnt == CNT_W'(POLL_GAP - 1)) begin
          w_slot_nxt  = w_first_pend[IDX_W-1:0];
          w_cnt_nxt   = '0;
          w_state_nxt = w_first_pend[IDX_W] ? CHECK : DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pending  <= '0;
      r_quiesced <= '0;
      r_slot     <= '0;
      r_sweep    <= '0;
      r_cnt      <= '0;
      r_done_q   <= '0;
      r_done_t   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pending_nxt;
      r_quiesced <= w_quiesced_nxt;
      r_slot     <= w_slot_nxt;
      r_sweep    <= w_sweep_nxt;
      r_cnt      <= w_cnt_nxt;
      // Capture the reported masks so they hold after the DONE pulse.
      if (r_state == DONE) begin
        r_done_q <= r_quiesced;
        r_done_t <= r_pending;
      end
    end
  end

  // cmd_ready is gated by rst so nothing is accepted during the reset cycle.
  assign bus.cmd_ready        = (r_state == IDLE) && !rst;
  assign bus.q_req_valid      = (r_state == ISSUE || r_state == CHECK) ? w_slot_oh : '0;
  assign bus.q_req_is_request = (r_state == ISSUE);
  assign bus.done_valid       = (r_state == DONE);
  assign bus.done_quiesced    = (r_state == DONE) ? r_quiesced : r_done_q;
  assign bus.done_timeout     = (r_state == DONE) ? r_pending  : r_done_t;

`ifdef QUIESCE_SEQ_CYCLES_EN
  logic [31:0] r_cycles, r_done_cyc;
  logic        w_busy;

  assign w_busy = (r_state == ISSUE) || (r_state == CHECK) || (r_state == GAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycles   <= '0;
      r_done_cyc <= '0;
    end else begin
      if (w_accept) begin
        r_cycles <= '0;
      end else if (w_busy && r_cycles != 32'hFFFF_FFFF) begin
        r_cycles <= r_cycles + 32'd1;
      end
      if (r_state == DONE) r_done_cyc <= r_cycles;
    end
  end

  assign bus.done_cycles = (r_state == DONE) ? r_cycles : r_done_cyc;
`else
  assign bus.done_cycles = '0;
`endif

endmodule

// File: tb/tb_quiesce_sequencer.sv
// Purpose : directed bench for quiesce_sequencer; dut_a uses default parameters,
//           dut_b uses MAX_SWEEPS=2. A scripted slot responder answers checks.
// Ports   : none (top level).
module tb_quiesce_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       sel;
  logic       cmd_valid;
  logic [7:0] cmd_mask;
  logic [7:0] resp_v, resp_d;

  quiesce_sequencer_if #(.NUM_SLOTS(8)) bus_a ();
  quiesce_sequencer_if #(.NUM_SLOTS(8)) bus_b ();

  quiesce_sequencer #(.NUM_SLOTS(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.master));
  quiesce_sequencer #(.NUM_SLOTS(8), .MAX_SWEEPS(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.master));

  assign bus_a.cmd_valid       = cmd_valid & ~sel;
  assign bus_b.cmd_valid       = cmd_valid & sel;
  assign bus_a.cmd_mask        = cmd_mask;
  assign bus_b.cmd_mask        = cmd_mask;
  assign bus_a.q_resp_valid    = sel ? 8'h00 : resp_v;
  assign bus_b.q_resp_valid    = sel ? resp_v : 8'h00;
  assign bus_a.q_resp_quiesced = resp_d;
  assign bus_b.q_resp_quiesced = resp_d;

  logic        o_ready, o_done_v, o_is_req;
  logic [7:0]  o_req, o_done_q, o_done_t;
  logic [31:0] o_cyc;
  assign o_ready  = sel ? bus_b.cmd_ready        : bus_a.cmd_ready;
  assign o_done_v = sel ? bus_b.done_valid       : bus_a.done_valid;
  assign o_is_req = sel ? bus_b.q_req_is_request : bus_a.q_req_is_request;
  assign o_req    = sel ? bus_b.q_req_valid      : bus_a.q_req_valid;
  assign o_done_q = sel ? bus_b.done_quiesced    : bus_a.done_quiesced;
  assign o_done_t = sel ? bus_b.done_timeout     : bus_a.done_timeout;
  assign o_cyc    = sel ? bus_b.done_cycles      : bus_a.done_cycles;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Responder script: answer k of slot s is ans[s][k] (1 after eight answers);
  // answers come in the second cycle of a check; silent slots never answer.
  logic [7:0] ans [0:7];
  logic [7:0] silent;
  bit         spur_en;

  initial begin
    logic [7:0] prev, cur, nv, nd;
    int age [0:7];
    int nresp [0:7];
    resp_v = '0;
    resp_d = '0;
    prev   = '0;
    for (int s = 0; s < 8; s++) begin
      age[s]   = 0;
      nresp[s] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      cur = o_is_req ? 8'h00 : o_req;
      if (o_is_req) for (int s = 0; s < 8; s++) nresp[s] = 0;
      nv = '0;
      nd = '0;
      for (int s = 0; s < 8; s++) begin
        if (cur[s]) begin
          age[s] = prev[s] ? age[s] + 1 : 0;
          if (age[s] == 1 && !silent[s]) begin
            nv[s] = 1'b1;
            nd[s] = (nresp[s] < 8) ? ans[s][nresp[s]] : 1'b1;
            nresp[s]++;
          end
        end
      end
      if (spur_en && cur[0] && age[0] == 0) begin
        nv[3] = 1'b1;
        nd[3] = 1'b1;
      end
      prev   = cur;
      resp_v = nv;
      resp_d = nd;
    end
  end

  logic [7:0]  issue_log [0:7];
  int          n_issue, k_done, idle_cyc;
  int          chk_cyc [0:7];
  bit          got_done;
  logic [7:0]  r_q, r_t, req_at_done;
  logic [31:0] r_cyc;

  task automatic run_cmd(input logic [7:0] mask, input int budget);
    n_issue  = 0;
    idle_cyc = 0;
    k_done   = 0;
    got_done = 0;
    for (int s = 0; s < 8; s++) chk_cyc[s] = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_mask  = mask;
    @(negedge clk);
    chk("cmd_ready", 32'(o_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 1; k <= budget && !got_done; k++) begin
      @(negedge clk);
      if (o_req != 0 && o_is_req) begin
        if (n_issue < 8) issue_log[n_issue] = o_req;
        n_issue++;
      end
      for (int s = 0; s < 8; s++) if (o_req[s] && !o_is_req) chk_cyc[s]++;
      if (o_req == 0 && !o_done_v) idle_cyc++;
      if (o_done_v) begin
        got_done    = 1;
        k_done      = k;
        r_q         = o_done_q;
        r_t         = o_done_t;
        r_cyc       = o_cyc;
        req_at_done = o_req;
      end
    end
    chk("done_seen", 32'(got_done), 32'd1);
  endtask

  initial begin
    int n_done, n_req;
    sel       = 1'b0;
    cmd_valid = 1'b0;
    cmd_mask  = '0;
    silent    = '0;
    spur_en   = 0;
    for (int s = 0; s < 8; s++) ans[s] = 8'hFF;
    rst = 1'b1;

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_done_v", 32'(o_done_v), 32'd0);
    chk("rst_req", 32'(o_req), 32'd0);
    chk("rst_done_q", 32'(o_done_q), 32'd0);
    chk("rst_done_t", 32'(o_done_t), 32'd0);
    chk("rst_cycles", o_cyc, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(o_ready), 32'd1);

    // Mask 0x05, both slots quiesce on first check
    run_cmd(8'h05, 50);
    chk("m05_n_issue", 32'(n_issue), 32'd2);
    chk("m05_issue0", 32'(issue_log[0]), 32'h01);
    chk("m05_issue1", 32'(issue_log[1]), 32'h04);
    chk("m05_done_q", 32'(r_q), 32'h05);
    chk("m05_done_t", 32'(r_t), 32'h00);
    chk("m05_latency", 32'(k_done), 32'd7);
    chk("m05_req_in_done", 32'(req_at_done), 32'd0);
`ifdef QUIESCE_SEQ_CYCLES_EN
    chk("m05_cycles_meas", r_cyc, 32'(k_done - 1));
    chk("m05_cycles", r_cyc, 32'd6);
`else
    chk("m05_cycles_off", r_cyc, 32'd0);
`endif
    @(negedge clk);
    chk("hold_done_v", 32'(o_done_v), 32'd0);
    chk("hold_done_q", 32'(o_done_q), 32'h05);
    chk("hold_ready", 32'(o_ready), 32'd1);

    // Zero mask
    run_cmd(8'h00, 10);
    chk("m00_latency", 32'(k_done), 32'd1);
    chk("m00_done_q", 32'(r_q), 32'h00);
    chk("m00_done_t", 32'(r_t), 32'h00);
    chk("m00_no_issue", 32'(n_issue), 32'd0);
    chk("m00_no_check", 32'(chk_cyc[0] + chk_cyc[1] + chk_cyc[2] + chk_cyc[3] +
                            chk_cyc[4] + chk_cyc[5] + chk_cyc[6] + chk_cyc[7]), 32'd0);

    // Slot 7 answers 0, 0, then 1: three sweeps, two gaps
    ans[7] = 8'h04;
    run_cmd(8'h80, 100);
    chk("m80_latency", 32'(k_done), 32'd40);
    chk("m80_gap_cycles", 32'(idle_cyc), 32'd32);
    chk("m80_check_cycles", 32'(chk_cyc[7]), 32'd6);
    chk("m80_done_q", 32'(r_q), 32'h80);
    chk("m80_done_t", 32'(r_t), 32'h00);

    // Reset while in GAP abandons the command silently
    ans[7] = 8'h00;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_mask  = 8'h80;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("gap_req", 32'(o_req), 32'd0);
    chk("gap_ready", 32'(o_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("gaprst_ready", 32'(o_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    n_done = 0;
    n_req  = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_done_v) n_done++;
      if (o_req != 0) n_req++;
    end
    chk("gaprst_no_done", 32'(n_done), 32'd0);
    chk("gaprst_no_req", 32'(n_req), 32'd0);
    chk("gaprst_ready", 32'(o_ready), 32'd1);
    chk("gaprst_done_q", 32'(o_done_q), 32'd0);

    // MAX_SWEEPS=2 instance: slot 1 never answers
    sel    = 1'b1;
    ans[0] = 8'hFF;
    silent = 8'h02;
    run_cmd(8'h03, 300);
    chk("m03_latency", 32'(k_done), 32'd149);
    chk("m03_slot1_check", 32'(chk_cyc[1]), 32'd128);
    chk("m03_slot0_check", 32'(chk_cyc[0]), 32'd2);
    chk("m03_done_q", 32'(r_q), 32'h01);
    chk("m03_done_t", 32'(r_t), 32'h02);

    // Spurious slot-3 response during slot-0 check is ignored
    silent  = 8'h00;
    ans[3]  = 8'h00;
    spur_en = 1;
    run_cmd(8'h09, 100);
    spur_en = 0;
    chk("spur_done_q", 32'(r_q), 32'h01);
    chk("spur_done_t", 32'(r_t), 32'h08);
    chk("spur_latency", 32'(k_done), 32'd25);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
